// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU operand sequencer: state encodings and ALU function codes.
// The accumulator-chain option is selected in alu_op_sequencer with `define ALU_SEQ_ACCUM_EN.
package alu_seq_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_LD_A = 3'd0,
    ST_LD_B = 3'd1,
    ST_LD_F = 3'd2,
    ST_EXEC = 3'd3,
    ST_SHOW = 3'd4
  } state_e;

  // Function codes understood by the ALU datapath (low OP_W bits of the switch bus).
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SLL  = 4'd1;
  localparam logic [3:0] ALU_SLT  = 4'd2;
  localparam logic [3:0] ALU_SLTU = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SRL  = 4'd5;
  localparam logic [3:0] ALU_SRA  = 4'd6;
  localparam logic [3:0] ALU_OR   = 4'd7;
  localparam logic [3:0] ALU_AND  = 4'd8;
  localparam logic [3:0] ALU_SUB  = 4'd9;

  // Operand-loading states preview the live switch value on the display.
  function automatic logic is_load_state(input state_e s);
    return (s == ST_LD_A) || (s == ST_LD_B) || (s == ST_LD_F);
  endfunction

endpackage

// File: rtl/step_debounce.sv
// Step-button conditioning: 2-flop synchroniser, stability counter and a one-cycle
// pulse on each accepted rising edge. A press is accepted after DB_CYCLES stable cycles.
module step_debounce #(
  parameter int DB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_step
);

  localparam int CNT_W = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_stable;
  logic             r_prev;
  logic             r_pulse;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
    end
  end

  // Any return to the accepted level restarts the count, so short bounces never land.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else if (r_sync2 == r_stable) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_MAX) begin
      r_stable <= r_sync2;
      r_cnt    <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev  <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_prev  <= r_stable;
      r_pulse <= r_stable & ~r_prev;
    end
  end

  assign o_step = r_pulse;

endmodule

// File: rtl/alu_op_sequencer.sv
// Step-button driven operand/function loader and result capture for the ALU board top.
// Optional feature: `define ALU_SEQ_ACCUM_EN lets SHOW chain the result back into operand A.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int OP_W      = 4,
  parameter int FLAG_W    = 4,
  parameter int ALU_LAT   = 1,
  parameter int DB_CYCLES = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_step,
  input  logic               use_acc,
  input  logic [DATA_W-1:0]  sw,
  input  logic [DATA_W-1:0]  alu_result,
  input  logic [FLAG_W-1:0]  alu_flags,
  output logic [DATA_W-1:0]  op_a,
  output logic [DATA_W-1:0]  op_b,
  output logic [OP_W-1:0]    op_f,
  output logic               alu_go,
  output logic [DATA_W-1:0]  res_q,
  output logic [FLAG_W-1:0]  flags_q,
  output logic [DATA_W-1:0]  disp_word,
  output logic [STATE_W-1:0] state_q,
  output logic               done
);

  localparam logic [3:0] LAT_LOAD = 4'(ALU_LAT);

  state_e              r_state;
  state_e              w_next;
  logic [3:0]          r_lat;
  logic [DATA_W-1:0]   r_op_a;
  logic [DATA_W-1:0]   r_op_b;
  logic [OP_W-1:0]     r_op_f;
  logic [DATA_W-1:0]   r_res;
  logic [FLAG_W-1:0]   r_flags;
  logic                r_go;
  logic                w_step;
  logic                w_load_a;
  logic                w_load_b;
  logic                w_load_f;
  logic                w_capture;
  logic                w_acc_load;
  logic [DATA_W-1:0]   w_disp;

  step_debounce #(
    .DB_CYCLES (DB_CYCLES)
  ) u_step_debounce (
    .clk    (clk),
    .rst    (rst),
    .i_btn  (btn_step),
    .o_step (w_step)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_LD_A;
    end else begin
      r_state <= w_next;
    end
  end

  // A step arriving in EXEC is simply not looked at, which is what drops it.
  always_comb begin
    w_next     = r_state;
    w_load_a   = 1'b0;
    w_load_b   = 1'b0;
    w_load_f   = 1'b0;
    w_capture  = 1'b0;
    w_acc_load = 1'b0;
    case (r_state)
      ST_LD_A: begin
        if (w_step) begin
          w_load_a = 1'b1;
          w_next   = ST_LD_B;
        end
      end
      ST_LD_B: begin
        if (w_step) begin
          w_load_b = 1'b1;
          w_next   = ST_LD_F;
        end
      end
      ST_LD_F: begin
        if (w_step) begin
          w_load_f = 1'b1;
          w_next   = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (r_lat == 4'd0) begin
          w_capture = 1'b1;
          w_next    = ST_SHOW;
        end
      end
      ST_SHOW: begin
        if (w_step) begin
`ifdef ALU_SEQ_ACCUM_EN
          if (use_acc) begin
            w_acc_load = 1'b1;
            w_next     = ST_LD_B;
          end else begin
            w_next = ST_LD_A;
          end
`else
          w_next = ST_LD_A;
`endif
        end
      end
      default: w_next = ST_LD_A;
    endcase
  end

`ifndef ALU_SEQ_ACCUM_EN
  logic w_unused_use_acc;
  assign w_unused_use_acc = use_acc;
`endif

  // The launch pulse is registered off the LD_F load so it coincides with the first EXEC cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op_a  <= '0;
      r_op_b  <= '0;
      r_op_f  <= '0;
      r_res   <= '0;
      r_flags <= '0;
      r_go    <= 1'b0;
      r_lat   <= 4'd0;
    end else begin
      r_go <= w_load_f;
      if (w_load_a) begin
        r_op_a <= sw;
      end else if (w_acc_load) begin
        r_op_a <= r_res;
      end
      if (w_load_b) begin
        r_op_b <= sw;
      end
      if (w_load_f) begin
        r_op_f <= sw[OP_W-1:0];
        r_lat  <= LAT_LOAD;
      end else if ((r_state == ST_EXEC) && (r_lat != 4'd0)) begin
        r_lat <= r_lat - 4'd1;
      end
      if (w_capture) begin
        r_res   <= alu_result;
        r_flags <= alu_flags;
      end
    end
  end

  always_comb begin
    w_disp = r_res;
    if (is_load_state(r_state)) begin
      w_disp = sw;
    end
  end

  assign op_a      = r_op_a;
  assign op_b      = r_op_b;
  assign op_f      = r_op_f;
  assign alu_go    = r_go;
  assign res_q     = r_res;
  assign flags_q   = r_flags;
  assign disp_word = w_disp;
  assign state_q   = r_state;
  assign done      = (r_state == ST_SHOW);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: one instance at ALU_LAT=1/DB_CYCLES=16, a second
// at ALU_LAT=8/DB_CYCLES=2 for the EXEC drop and reset-abort scenarios.
module tb_alu_op_sequencer;
  import alu_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst, rst2;
  logic        btnStep, btnStep2;
  logic        useAcc, useAcc2;
  logic [31:0] sw, sw2;
  logic [31:0] aluResult, aluResult2;
  logic [3:0]  aluFlags, aluFlags2;
  logic [31:0] opA, opB, opA2, opB2;
  logic [3:0]  opF, opF2;
  logic        aluGo, aluGo2;
  logic [31:0] resQ, resQ2;
  logic [3:0]  flagsQ, flagsQ2;
  logic [31:0] dispWord, dispWord2;
  logic [2:0]  stateQ, stateQ2;
  logic        done, done2;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int goCount = 0;
  int goCount2 = 0;
  int goCyc = 0;
  int doneCyc = 0;
  logic prevDone = 1'b0;
  logic [2:0] lastState = 3'd0;
  logic [2:0] stateLog[$];

  always #5 clk = ~clk;

  alu_op_sequencer #(.DATA_W(32), .OP_W(4), .FLAG_W(4), .ALU_LAT(1), .DB_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .btn_step(btnStep), .use_acc(useAcc), .sw(sw),
    .alu_result(aluResult), .alu_flags(aluFlags), .op_a(opA), .op_b(opB), .op_f(opF),
    .alu_go(aluGo), .res_q(resQ), .flags_q(flagsQ), .disp_word(dispWord),
    .state_q(stateQ), .done(done)
  );

  alu_op_sequencer #(.DATA_W(32), .OP_W(4), .FLAG_W(4), .ALU_LAT(8), .DB_CYCLES(2)) dut2 (
    .clk(clk), .rst(rst2), .btn_step(btnStep2), .use_acc(useAcc2), .sw(sw2),
    .alu_result(aluResult2), .alu_flags(aluFlags2), .op_a(opA2), .op_b(opB2), .op_f(opF2),
    .alu_go(aluGo2), .res_q(resQ2), .flags_q(flagsQ2), .disp_word(dispWord2),
    .state_q(stateQ2), .done(done2)
  );

  function automatic logic [31:0] aluModel(input logic [31:0] a, input logic [31:0] b, input logic [3:0] f);
    case (f)
      ALU_ADD:  return a + b;
      ALU_SLL:  return a << b[4:0];
      ALU_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
      ALU_XOR:  return a ^ b;
      ALU_SRL:  return a >> b[4:0];
      ALU_SRA:  return $signed(a) >>> b[4:0];
      ALU_OR:   return a | b;
      ALU_AND:  return a & b;
      ALU_SUB:  return a - b;
      default:  return 32'd0;
    endcase
  endfunction

  function automatic logic [3:0] flagModel(input logic [31:0] a, input logic [31:0] b, input logic [3:0] f);
    logic [32:0] sum;
    logic [31:0] res;
    logic        carry;
    logic        ovf;
    res   = aluModel(a, b, f);
    sum   = {1'b0, a} + {1'b0, b};
    carry = (f == ALU_ADD) ? sum[32] : 1'b0;
    ovf   = (f == ALU_ADD) ? ((a[31] == b[31]) && (res[31] != a[31])) : 1'b0;
    return {(res == 32'd0), res[31], carry, ovf};
  endfunction

  // Registered ALU with one cycle of latency; garbage outside the valid cycle.
  always @(posedge clk) begin
    if (aluGo) begin
      aluResult <= aluModel(opA, opB, opF);
      aluFlags  <= flagModel(opA, opB, opF);
    end else begin
      aluResult <= 32'hDEADBEEF;
      aluFlags  <= 4'hF;
    end
  end

  assign aluResult2 = aluModel(opA2, opB2, opF2);
  assign aluFlags2  = flagModel(opA2, opB2, opF2);

  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (aluGo) begin
      goCount = goCount + 1;
      goCyc   = cyc;
    end
    if (aluGo2) goCount2 = goCount2 + 1;
    if (done && !prevDone) doneCyc = cyc;
    prevDone = done;
    if (stateQ != lastState) begin
      stateLog.push_back(stateQ);
      lastState = stateQ;
    end
  end

  task automatic pressStep(input logic [31:0] val);
    sw = val;
    btnStep = 1'b1;
    repeat (30) @(posedge clk);
    #1 btnStep = 1'b0;
    repeat (30) @(posedge clk);
    #1;
  endtask

  task automatic pressStep2(input logic [31:0] val);
    sw2 = val;
    btnStep2 = 1'b1;
    repeat (10) @(posedge clk);
    #1 btnStep2 = 1'b0;
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; rst2 = 1'b1;
    sw = 32'h12345678; sw2 = 32'h0;
    btnStep = 1'b0; btnStep2 = 1'b0; useAcc = 1'b0; useAcc2 = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0; rst2 = 1'b0;
    @(posedge clk); #1;
    vectors++; if (stateQ !== 3'd0) begin miscompares++; $display("[TB] FAIL reset_state: got %0d expected 0", stateQ); end
    vectors++; if (opA !== 32'd0 || opB !== 32'd0) begin miscompares++; $display("[TB] FAIL reset_ops: got %h/%h expected 0/0", opA, opB); end
    vectors++; if (opF !== 4'd0) begin miscompares++; $display("[TB] FAIL reset_opf: got %h expected 0", opF); end
    vectors++; if (resQ !== 32'd0 || flagsQ !== 4'd0) begin miscompares++; $display("[TB] FAIL reset_res: got %h/%h expected 0/0", resQ, flagsQ); end
    vectors++; if (aluGo !== 1'b0 || done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_go_done: got %b/%b expected 0/0", aluGo, done); end
    vectors++; if (dispWord !== 32'h12345678) begin miscompares++; $display("[TB] FAIL reset_disp: got %h expected 12345678", dispWord); end
    vectors++; if (stateQ2 !== 3'd0) begin miscompares++; $display("[TB] FAIL reset_state2: got %0d expected 0", stateQ2); end
  endtask

  task automatic test_add_overflow;
    goCount = 0;
    pressStep(32'hFFFFFFFF);
    pressStep(32'hFFFFFFFF);
    pressStep(32'h00000000);
    vectors++; if (goCount !== 1) begin miscompares++; $display("[TB] FAIL add_go_width: got %0d cycles expected 1", goCount); end
    vectors++; if (doneCyc - goCyc !== 2) begin miscompares++; $display("[TB] FAIL add_capture_delay: got %0d expected 2", doneCyc - goCyc); end
    vectors++; if (resQ !== 32'hFFFFFFFE) begin miscompares++; $display("[TB] FAIL add_res: got %h expected FFFFFFFE", resQ); end
    vectors++; if (flagsQ !== 4'b0110) begin miscompares++; $display("[TB] FAIL add_flags: got %b expected 0110", flagsQ); end
    vectors++; if (done !== 1'b1 || stateQ !== 3'd4) begin miscompares++; $display("[TB] FAIL add_done: got %b/%0d expected 1/4", done, stateQ); end
    vectors++; if (dispWord !== 32'hFFFFFFFE) begin miscompares++; $display("[TB] FAIL add_disp: got %h expected FFFFFFFE", dispWord); end
    pressStep(32'h0);
    vectors++; if (stateQ !== 3'd0) begin miscompares++; $display("[TB] FAIL add_return: got %0d expected 0", stateQ); end
  endtask

  task automatic test_shift;
    stateLog.delete();
    pressStep(32'h1);
    pressStep(32'h2);
    pressStep(32'h1);
    vectors++; if (resQ !== 32'h00000004) begin miscompares++; $display("[TB] FAIL sll_res: got %h expected 00000004", resQ); end
    vectors++;
    if (stateLog.size() != 4 || stateLog[0] !== 3'd1 || stateLog[1] !== 3'd2 || stateLog[2] !== 3'd3 || stateLog[3] !== 3'd4) begin
      miscompares++;
      $display("[TB] FAIL sll_state_walk: got %0d transitions (%p) expected 1,2,3,4", stateLog.size(), stateLog);
    end
    pressStep(32'h0);
  endtask

  task automatic test_signed_compare;
    pressStep(32'hA0000001);
    pressStep(32'h1);
    pressStep(32'h2);
    vectors++; if (resQ !== 32'd1) begin miscompares++; $display("[TB] FAIL slt_neg: got %h expected 00000001", resQ); end
    pressStep(32'h0);
    pressStep(32'h2);
    pressStep(32'h1);
    pressStep(32'h2);
    vectors++; if (resQ !== 32'd0) begin miscompares++; $display("[TB] FAIL slt_pos: got %h expected 00000000", resQ); end
    pressStep(32'h0);
  endtask

  task automatic test_bounce_hold;
    sw = 32'h55;
    btnStep = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (i % 3 == 0) btnStep = ~btnStep;
      @(posedge clk); #1;
    end
    btnStep = 1'b0;
    repeat (5) @(posedge clk); #1;
    vectors++; if (stateQ !== 3'd0) begin miscompares++; $display("[TB] FAIL bounce_no_step: got %0d expected 0", stateQ); end
    btnStep = 1'b1;
    repeat (200) @(posedge clk); #1;
    vectors++; if (stateQ !== 3'd1) begin miscompares++; $display("[TB] FAIL hold_one_step: got %0d expected 1", stateQ); end
    btnStep = 1'b0;
    repeat (30) @(posedge clk); #1;
    vectors++; if (stateQ !== 3'd1 || opA !== 32'h55) begin miscompares++; $display("[TB] FAIL release_no_step: got %0d/%h expected 1/00000055", stateQ, opA); end
    pressStep(32'h7);
    pressStep(32'h0);
    vectors++; if (resQ !== 32'h5C) begin miscompares++; $display("[TB] FAIL bounce_add: got %h expected 0000005C", resQ); end
    pressStep(32'h0);
  endtask

  task automatic test_accumulator;
    pressStep(32'h1);
    pressStep(32'h1);
    pressStep(32'h0);
    vectors++; if (resQ !== 32'h2) begin miscompares++; $display("[TB] FAIL acc_first: got %h expected 00000002", resQ); end
    useAcc = 1'b1;
    pressStep(32'hCAFE);
    useAcc = 1'b0;
`ifdef ALU_SEQ_ACCUM_EN
    vectors++; if (stateQ !== 3'd1 || opA !== 32'h2) begin miscompares++; $display("[TB] FAIL acc_chain: got %0d/%h expected 1/00000002", stateQ, opA); end
    pressStep(32'h3);
    pressStep(32'h0);
    vectors++; if (resQ !== 32'h5) begin miscompares++; $display("[TB] FAIL acc_sum: got %h expected 00000005", resQ); end
`else
    vectors++; if (stateQ !== 3'd0 || opA !== 32'h1) begin miscompares++; $display("[TB] FAIL acc_ignored: got %0d/%h expected 0/00000001", stateQ, opA); end
    pressStep(32'h9);
    vectors++; if (stateQ !== 3'd1 || opA !== 32'h9) begin miscompares++; $display("[TB] FAIL acc_reload: got %0d/%h expected 1/00000009", stateQ, opA); end
    pressStep(32'h3);
    pressStep(32'h0);
    vectors++; if (resQ !== 32'hC) begin miscompares++; $display("[TB] FAIL acc_plain_sum: got %h expected 0000000C", resQ); end
`endif
    pressStep(32'h0);
  endtask

  task automatic waitExec2(output bit found);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clk); #1;
      if (stateQ2 == 3'd3) found = 1'b1;
    end
    vectors++;
    if (!found) begin miscompares++; $display("[TB] FAIL exec_entry_timeout: got state %0d expected 3", stateQ2); end
  endtask

  task automatic test_drop_in_exec;
    bit found;
    pressStep2(32'd11);
    pressStep2(32'd22);
    sw2 = 32'd0;
    btnStep2 = 1'b1;
    waitExec2(found);
    btnStep2 = 1'b0;
    repeat (2) @(posedge clk);
    #1 btnStep2 = 1'b1;
    repeat (5) @(posedge clk); #1;
    vectors++; if (stateQ2 !== 3'd3) begin miscompares++; $display("[TB] FAIL drop_still_exec: got %0d expected 3", stateQ2); end
    btnStep2 = 1'b0;
    repeat (10) @(posedge clk); #1;
    vectors++; if (stateQ2 !== 3'd4 || done2 !== 1'b1) begin miscompares++; $display("[TB] FAIL drop_show: got %0d/%b expected 4/1", stateQ2, done2); end
    vectors++; if (resQ2 !== 32'd33) begin miscompares++; $display("[TB] FAIL drop_res: got %h expected 00000021", resQ2); end
    repeat (10) @(posedge clk); #1;
    vectors++; if (stateQ2 !== 3'd4) begin miscompares++; $display("[TB] FAIL drop_not_queued: got %0d expected 4", stateQ2); end
    pressStep2(32'd0);
    vectors++; if (stateQ2 !== 3'd0) begin miscompares++; $display("[TB] FAIL drop_return: got %0d expected 0", stateQ2); end
  endtask

  task automatic test_reset_mid_exec;
    bit found;
    pressStep2(32'd5);
    pressStep2(32'd6);
    sw2 = 32'd0;
    btnStep2 = 1'b1;
    waitExec2(found);
    btnStep2 = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst2 = 1'b1;
    @(posedge clk); #1;
    rst2 = 1'b0;
    vectors++; if (stateQ2 !== 3'd0 || done2 !== 1'b0 || aluGo2 !== 1'b0) begin miscompares++; $display("[TB] FAIL abort_ctrl: got %0d/%b/%b expected 0/0/0", stateQ2, done2, aluGo2); end
    vectors++; if (opA2 !== 32'd0 || opB2 !== 32'd0 || opF2 !== 4'd0) begin miscompares++; $display("[TB] FAIL abort_ops: got %h/%h/%h expected 0/0/0", opA2, opB2, opF2); end
    vectors++; if (resQ2 !== 32'd0 || flagsQ2 !== 4'd0) begin miscompares++; $display("[TB] FAIL abort_res: got %h/%h expected 0/0", resQ2, flagsQ2); end
    goCount2 = 0;
    repeat (20) @(posedge clk); #1;
    vectors++; if (goCount2 !== 0 || resQ2 !== 32'd0 || stateQ2 !== 3'd0) begin miscompares++; $display("[TB] FAIL abort_no_capture: got go=%0d res=%h state=%0d expected 0/0/0", goCount2, resQ2, stateQ2); end
  endtask

  initial begin
    test_reset();
    test_add_overflow();
    test_shift();
    test_signed_compare();
    test_bounce_hold();
    test_accumulator();
    test_drop_in_exec();
    test_reset_mid_exec();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
